// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the display data processor.
// Latency: n/a (signal bundle only).
// Backpressure: none; the producer free-runs and the consumer samples every cycle.
//
// Signals: hs/vs sync levels, hen/ven active-area enables, frame_start pulse,
// and x/y active-area position when VGA_POS_OUT_EN is defined.
interface vga_timing_if;
    logic       hs;
    logic       vs;
    logic       hen;
    logic       ven;
    logic       frame_start;
`ifdef VGA_POS_OUT_EN
    logic [9:0] x;
    logic [9:0] y;

    modport master (output hs, vs, hen, ven, frame_start, x, y);
    modport slave  (input  hs, vs, hen, ven, frame_start, x, y);
`else
    modport master (output hs, vs, hen, ven, frame_start);
    modport slave  (input  hs, vs, hen, ven, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// 800x600@72Hz raster timing generator: hs, vs, hen, ven, frame_start (+ x/y).
// Latency: outputs are registered from the next state, so they change on the edge the state does.
// Backpressure: none; free-runs every pclk cycle, no handshake.
//
// Ports:
//   pclk  - pixel clock, all logic on the rising edge
//   rst   - synchronous active-high reset
//   vif   - vga_timing_if.master: hs, vs, hen, ven, frame_start, x, y
// Optional feature macro: VGA_POS_OUT_EN adds the x/y active-area position outputs.
// Every phase-length parameter must be >= 1.
module vga_timing_gen #(
    parameter int HSW    = 120,
    parameter int HBP    = 64,
    parameter int HACT   = 800,
    parameter int HFP    = 56,
    parameter int VSW    = 6,
    parameter int VBP    = 23,
    parameter int VACT   = 600,
    parameter int VFP    = 37,
    parameter int HS_POL = 1,
    parameter int VS_POL = 1
) (
    input  logic         pclk,
    input  logic         rst,
    vga_timing_if.master vif
);

    typedef enum logic [1:0] {H_SYNC, H_BP, H_ACT, H_FP} hstate_t;
    typedef enum logic [1:0] {V_SYNC, V_BP, V_ACT, V_FP} vstate_t;

    localparam logic [10:0] HSW_M1  = 11'(HSW - 1);
    localparam logic [10:0] HBP_M1  = 11'(HBP - 1);
    localparam logic [10:0] HACT_M1 = 11'(HACT - 1);
    localparam logic [10:0] HFP_M1  = 11'(HFP - 1);
    localparam logic [9:0]  VSW_M1  = 10'(VSW - 1);
    localparam logic [9:0]  VBP_M1  = 10'(VBP - 1);
    localparam logic [9:0]  VACT_M1 = 10'(VACT - 1);
    localparam logic [9:0]  VFP_M1  = 10'(VFP - 1);
    localparam logic        HS_ON   = (HS_POL != 0);
    localparam logic        VS_ON   = (VS_POL != 0);

    hstate_t     hstate, hstate_n;
    vstate_t     vstate, vstate_n;
    logic [10:0] hc, hc_n, h_len_m1;
    logic [9:0]  vc, vc_n, v_len_m1;
    logic        h_last, v_last, eol;

    logic        hs_q, vs_q, hen_q, ven_q, fs_q;
    logic        hs_d, vs_d, hen_d, ven_d, fs_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            hstate <= H_SYNC;
            vstate <= V_SYNC;
            hc     <= '0;
            vc     <= '0;
            hs_q   <= HS_ON;
            vs_q   <= VS_ON;
            hen_q  <= 1'b0;
            ven_q  <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hstate <= hstate_n;
            vstate <= vstate_n;
            hc     <= hc_n;
            vc     <= vc_n;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            hen_q  <= hen_d;
            ven_q  <= ven_d;
            fs_q   <= fs_d;
        end
    end

    always_comb begin
        h_len_m1 = HSW_M1;
        hstate_n = hstate;
        case (hstate)
            H_SYNC:  h_len_m1 = HSW_M1;
            H_BP:    h_len_m1 = HBP_M1;
            H_ACT:   h_len_m1 = HACT_M1;
            default: h_len_m1 = HFP_M1;
        endcase
        h_last = (hc == h_len_m1);
        hc_n   = h_last ? 11'd0 : hc + 11'd1;
        if (h_last) begin
            case (hstate)
                H_SYNC:  hstate_n = H_BP;
                H_BP:    hstate_n = H_ACT;
                H_ACT:   hstate_n = H_FP;
                default: hstate_n = H_SYNC;
            endcase
        end

        // The vertical axis only moves at end of line (last cycle of H_FP).
        eol      = h_last && (hstate == H_FP);
        v_len_m1 = VSW_M1;
        vstate_n = vstate;
        case (vstate)
            V_SYNC:  v_len_m1 = VSW_M1;
            V_BP:    v_len_m1 = VBP_M1;
            V_ACT:   v_len_m1 = VACT_M1;
            default: v_len_m1 = VFP_M1;
        endcase
        v_last = (vc == v_len_m1);
        vc_n   = vc;
        if (eol) begin
            vc_n = v_last ? 10'd0 : vc + 10'd1;
            if (v_last) begin
                case (vstate)
                    V_SYNC:  vstate_n = V_BP;
                    V_BP:    vstate_n = V_ACT;
                    V_ACT:   vstate_n = V_FP;
                    default: vstate_n = V_SYNC;
                endcase
            end
        end

        // Decode from the next state so the registered outputs line up with it.
        hs_d  = (hstate_n == H_SYNC) ? HS_ON : ~HS_ON;
        vs_d  = (vstate_n == V_SYNC) ? VS_ON : ~VS_ON;
        hen_d = (hstate_n == H_ACT);
        ven_d = (vstate_n == V_ACT);
        // First pixel of the first active line; hc_n == 0 in H_ACT occurs once per line.
        fs_d  = hen_d && ven_d && (hc_n == 11'd0) && (vc_n == 10'd0);
    end

    assign vif.hs          = hs_q;
    assign vif.vs          = vs_q;
    assign vif.hen         = hen_q;
    assign vif.ven         = ven_q;
    assign vif.frame_start = fs_q;

`ifdef VGA_POS_OUT_EN
    logic [9:0] x_q, y_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (hen_d && ven_d) begin
            x_q <= 10'(hc_n);
            y_q <= vc_n;
        end else begin
            x_q <= '0;
            y_q <= '0;
        end
    end

    assign vif.x = x_q;
    assign vif.y = y_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates the 800x600 @ 72 Hz raster timing: hs, vs and the active-area enables hen/ven.
- Sits directly upstream of the display data processor. hen and ven feed that stage's pixel counters and its rgb gating; hs and vs go straight to the VGA connector.
- Runs on the 50 MHz pixel clock.
- Each axis is a four-phase state machine with a phase counter, so porch and sync lengths are exact and parameterisable.

## Interface
Parameters (name, default, meaning):
- HSW, 120, horizontal sync width in pixels
- HBP, 64, horizontal back porch
- HACT, 800, horizontal active pixels
- HFP, 56, horizontal front porch
- VSW, 6, vertical sync width in lines
- VBP, 23, vertical back porch
- VACT, 600, vertical active lines
- VFP, 37, vertical front porch
- HS_POL, 1, hs level while in sync (1 = active-high)
- VS_POL, 1, vs level while in sync

Ports:
- pclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- hen  out  1  horizontal active enable
- ven  out  1  vertical active enable
- frame_start  out  1  one-cycle pulse on the first active pixel of each frame
- x  out  10  active-area column, only with VGA_POS_OUT_EN
- y  out  10  active-area row, only with VGA_POS_OUT_EN

## Operation
- Horizontal FSM states, in order: H_SYNC (HSW cycles), H_BP (HBP), H_ACT (HACT), H_FP (HFP), then back to H_SYNC.
  - Line length is 1040 cycles.
- Phase counter hc is 11 bits.
  - hc is cleared on every state change.
  - The state advances on the cycle where hc == phase length − 1.
- Vertical FSM states: V_SYNC (VSW), V_BP (VBP), V_ACT (VACT), V_FP (VFP), then back to V_SYNC.
  - Phase counter vc is 10 bits.
  - The vertical FSM steps only on the last cycle of H_FP (end of line).
  - Frame length is 666 lines = 692,640 cycles.
- Output decode:
  - hs = HS_POL while in H_SYNC, otherwise ~HS_POL.
  - vs is decoded the same way from V_SYNC and VS_POL.
  - hen = 1 iff in H_ACT.
  - ven = 1 iff in V_ACT.
- All outputs are registered from the next state, so they change on the same edge as the state they describe.
- frame_start = 1 for exactly one cycle: the cycle where hen & ven are first both 1 in a frame (V_ACT line 0, H_ACT pixel 0).
- Reset values, held while rst = 1 and on the first cycle after release:
  - both FSMs in their SYNC state, hc = vc = 0
  - hs = HS_POL, vs = VS_POL
  - hen = ven = frame_start = 0
  - x = y = 0
- Reset asserted mid-frame aborts the frame immediately. Timing restarts from line 0 of V_SYNC with no partial pulses.
- A phase parameter of 0 is illegal. Every parameter must be ≥ 1.

## Timing
- Cycle 0 after rst deasserts is the first H_SYNC cycle of V_SYNC line 0.
- hen first rises at cycle HSW+HBP = 184 of each line and falls after 800 cycles.
- hs is asserted during cycles 0–119 of each line.
- ven rises at the start of line VSW+VBP = 29 (on the line's first cycle, during H_SYNC) and falls at the start of line 629.
- vs and ven transitions coincide with the first cycle of an H_SYNC.
- frame_start occurs at cycle 29·1040 + 184 = 30,344 after reset release, then every 692,640 cycles.
- No input handshake. The generator free-runs every cycle.

## Configuration
- VGA_POS_OUT_EN defined:
  - x and y ports exist.
  - x = pixel index within H_ACT (0–799).
  - y = line index within V_ACT (0–599).
  - Both are valid in any cycle where hen & ven = 1, and hold 0 otherwise.
  - Both are registered and aligned with hen.
- Not defined: x and y ports and their logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset behaviour: hold rst for 5 cycles. Required: hs = vs = 1, hen = ven = frame_start = 0 throughout.
  - After release: hs stays 1 for exactly 120 cycles.
- Horizontal line: measure hs. Required: period 1040 cycles, width 120.
  - hen rises 184 cycles after the hs rising edge and is high for 800 consecutive cycles per line.
- Vertical frame: count lines. Required: vs high for 6 lines, ven high for 600 lines, frame 666 lines.
  - Required: 480,000 hen&ven cycles per frame.
- frame_start: required at cycle 30,344 after reset release, then again at 722,984.
  - Required: no other pulses in between.
- Mid-frame reset: assert rst for 1 cycle at line 300, pixel 400. Required: outputs match the post-reset state on the next cycle.
  - Required: next frame_start exactly 30,344 cycles after release.
- With VGA_POS_OUT_EN: required (x, y) = (0, 0) when frame_start fires, and (799, 599) on the last hen&ven cycle of the frame.
  - Required: x increments by 1 on each hen cycle.
